// File: rtl/id_ex_operand_stage_pkg.sv
// Shared encodings for the ID/EX operand stage: ALU operation codes and forwarding-source selects.
package id_ex_operand_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADDU = 4'd0,
        ALU_SUBU = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_LUI  = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_NOR  = 4'd11,
        ALU_XXX  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand bypass: picks EX/MEM, then MEM/WB, then the registered regfile value; $0 never bypassed.
module id_ex_operand_stage_fwd_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DW  = 32,
    parameter int RAW = 5
) (
    input  logic [RAW-1:0] i_src_addr,
    input  logic [DW-1:0]  i_rf_data,
    input  logic           i_exmem_reg_write,
    input  logic [RAW-1:0] i_exmem_rd,
    input  logic [DW-1:0]  i_exmem_result,
    input  logic           i_memwb_reg_write,
    input  logic [RAW-1:0] i_memwb_rd,
    input  logic [DW-1:0]  i_memwb_result,
    output logic [DW-1:0]  o_data
);

    fwd_sel_e w_sel;

    always_comb begin
        w_sel = FWD_RF;
        if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_src_addr)) begin
            w_sel = FWD_EXMEM;
        end else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_src_addr)) begin
            w_sel = FWD_MEMWB;
        end
    end

    always_comb begin
        o_data = i_rf_data;
        case (w_sel)
            FWD_EXMEM: o_data = i_exmem_result;
            FWD_MEMWB: o_data = i_memwb_result;
            default:   o_data = i_rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold, and forwarded ALU operand select.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DW  = 32,
    parameter int RAW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [RAW-1:0] id_rs_addr,
    input  logic [RAW-1:0] id_rt_addr,
    input  logic [RAW-1:0] id_rd_addr,
    input  logic [DW-1:0]  id_rs_data,
    input  logic [DW-1:0]  id_rt_data,
    input  logic [DW-1:0]  id_imm,
    input  logic [4:0]     id_shamt,
    input  logic [3:0]     id_alu_op,
    input  logic           id_use_imm,
    input  logic           id_shift_const,
    input  logic           id_shift_var,
    input  logic           id_uses_rs,
    input  logic           id_uses_rt,
    input  logic           id_reg_write,
    input  logic           id_mem_read,
    input  logic           id_mem_write,
    input  logic           stall_in,
    input  logic           flush,
    input  logic           exmem_reg_write,
    input  logic [RAW-1:0] exmem_rd,
    input  logic [DW-1:0]  exmem_result,
    input  logic           memwb_reg_write,
    input  logic [RAW-1:0] memwb_rd,
    input  logic [DW-1:0]  memwb_result,
    output logic           load_use_stall,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [3:0]     alu_op,
    output logic [DW-1:0]  ex_store_data,
    output logic [RAW-1:0] ex_rd,
    output logic           ex_valid,
    output logic           ex_reg_write,
    output logic           ex_mem_read,
    output logic           ex_mem_write
);

    logic           r_valid, r_reg_write, r_mem_read, r_mem_write;
    logic [RAW-1:0] r_rd, r_rs_addr, r_rt_addr;
    logic [3:0]     r_alu_op;
    logic [DW-1:0]  r_rs_data, r_rt_data, r_imm;
    logic [4:0]     r_shamt;
    logic           r_use_imm, r_shift_const, r_shift_var;

    logic           w_load_use, w_hold, w_bubble;
    logic [DW-1:0]  w_fwd_rs, w_fwd_rt;

    // A stalled EX stage cannot retire the load, so the hazard is only raised once the stall clears.
    assign w_load_use = !stall_in && r_mem_read && (r_rd != '0) && id_valid &&
                        ((id_uses_rs && (id_rs_addr == r_rd)) ||
                         (id_uses_rt && (id_rt_addr == r_rd)));
    assign w_hold     = stall_in && !flush;
    assign w_bubble   = flush || w_load_use || !id_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_rd          <= '0;
            r_alu_op      <= ALU_ADDU;
            r_rs_addr     <= '0;
            r_rt_addr     <= '0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
            r_shamt       <= '0;
            r_use_imm     <= 1'b0;
            r_shift_const <= 1'b0;
            r_shift_var   <= 1'b0;
        end else if (!w_hold) begin
            r_valid       <= !w_bubble;
            r_reg_write   <= !w_bubble && id_reg_write;
            r_mem_read    <= !w_bubble && id_mem_read;
            r_mem_write   <= !w_bubble && id_mem_write;
            r_rd          <= w_bubble ? '0 : id_rd_addr;
            r_alu_op      <= w_bubble ? ALU_ADDU : id_alu_op;
            r_rs_addr     <= id_rs_addr;
            r_rt_addr     <= id_rt_addr;
            r_rs_data     <= id_rs_data;
            r_rt_data     <= id_rt_data;
            r_imm         <= id_imm;
            r_shamt       <= id_shamt;
            r_use_imm     <= id_use_imm;
            r_shift_const <= id_shift_const;
            r_shift_var   <= id_shift_var;
        end
    end

    id_ex_operand_stage_fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd_rs (
        .i_src_addr        (r_rs_addr),
        .i_rf_data         (r_rs_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_data            (w_fwd_rs)
    );

    id_ex_operand_stage_fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd_rt (
        .i_src_addr        (r_rt_addr),
        .i_rf_data         (r_rt_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_data            (w_fwd_rt)
    );

    // Shifts operate on rt, so rt moves to the A port and the shift amount takes B.
    always_comb begin
        alu_a = (r_shift_const || r_shift_var) ? w_fwd_rt : w_fwd_rs;
        if (r_shift_const) begin
            alu_b = {{(DW-5){1'b0}}, r_shamt};
        end else if (r_shift_var) begin
            alu_b = {{(DW-5){1'b0}}, w_fwd_rs[4:0]};
        end else if (r_use_imm) begin
            alu_b = r_imm;
        end else begin
            alu_b = w_fwd_rt;
        end
    end

    assign load_use_stall = w_load_use;
    assign alu_op         = r_alu_op;
    assign ex_store_data  = w_fwd_rt;
    assign ex_rd          = r_rd;
    assign ex_valid       = r_valid;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_read    = r_mem_read;
    assign ex_mem_write   = r_mem_write;

endmodule
